// File: rtl/eth_buf_pkg.sv
// ----------------------------------------------------------------------------
// eth_buf_pkg
// Shared definitions for the receive-side frame buffer path: the 64-bit writer
// stage (eth_rx_frame_writer) and the 16-bit reader stage.
//   - geometry constants for port B and the two ping-pong slots
//   - writer FSM state encoding
//   - frame descriptor handed from writer to reader
//   - byte-enable population count used for frame length
// ----------------------------------------------------------------------------
package eth_buf_pkg;

    localparam int DATA_W     = 64;
    localparam int KEEP_W     = DATA_W / 8;
    localparam int ADDR_W     = 9;
    localparam int SLOT_WORDS = 256;
    localparam int LEN_W      = 12;
    localparam int MIN_LEN    = 60;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic             slot;
        logic [LEN_W-1:0] len;
    } frm_desc_t;

    // Number of valid bytes in a beat (tkeep is low-aligned and contiguous,
    // but a plain popcount does not rely on that).
    function automatic logic [3:0] keep_count(input logic [KEEP_W-1:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/eth_slot_tracker.sv
// ----------------------------------------------------------------------------
// eth_slot_tracker
// Bookkeeping for the two ping-pong frame slots.
//   clk, rst       : clock, synchronous active-high reset
//   commit         : frame in wslot accepted this cycle (tlast beat)
//   commit_len     : its length in bytes
//   ack            : consumer finished the slot shown in desc
//   wslot          : slot the writer fills next
//   occ            : per-slot occupancy
//   desc_valid     : occ[rslot]
//   desc           : {rslot, len[rslot]}
// wslot toggles on the commit beat so a frame starting on the very next beat
// already targets the other slot, while the occ bit is set one cycle later so
// the descriptor only appears after the final port-B write has landed.
// ----------------------------------------------------------------------------
module eth_slot_tracker
    import eth_buf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [LEN_W-1:0] commit_len,
    input  logic             ack,
    output logic             wslot,
    output logic [1:0]       occ,
    output logic             desc_valid,
    output frm_desc_t        desc
);

    logic [1:0]             occ_r;
    logic                   wslot_r;
    logic                   rslot_r;
    logic                   pend_r;
    logic                   pend_slot_r;
    logic [1:0][LEN_W-1:0]  len_r;

    logic [1:0]             occ_nxt_s;
    logic                   ack_ok_s;

    // Next occupancy: consumer release first, then the delayed commit set.
    always_comb begin
        occ_nxt_s = occ_r;
        ack_ok_s  = ack & occ_r[rslot_r];
        if (ack_ok_s) begin
            occ_nxt_s[rslot_r] = 1'b0;
        end else begin
            occ_nxt_s = occ_nxt_s;
        end
        if (pend_r) begin
            occ_nxt_s[pend_slot_r] = 1'b1;
        end else begin
            occ_nxt_s = occ_nxt_s;
        end
    end

    // Slot pointers, occupancy, pending-commit stage and length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r       <= 2'b00;
            wslot_r     <= 1'b0;
            rslot_r     <= 1'b0;
            pend_r      <= 1'b0;
            pend_slot_r <= 1'b0;
            len_r       <= {2{{LEN_W{1'b0}}}};
        end else begin
            occ_r       <= occ_nxt_s;
            rslot_r     <= rslot_r ^ ack_ok_s;
            wslot_r     <= wslot_r ^ commit;
            pend_r      <= commit;
            pend_slot_r <= wslot_r;
            if (commit) begin
                len_r[wslot_r] <= commit_len;
            end
        end
    end

    assign wslot      = wslot_r;
    assign occ        = occ_r;
    assign desc_valid = occ_r[rslot_r];
    assign desc.slot  = rslot_r;
    assign desc.len   = len_r[rslot_r];

endmodule

// File: rtl/eth_rx_frame_writer.sv
// ----------------------------------------------------------------------------
// eth_rx_frame_writer
// Writes 64-bit AXI-Stream frames from the MAC into two 256-word ping-pong
// slots of the frame buffer (port B) and publishes completed frames through a
// valid/ack descriptor. Errored, runt, oversize and no-free-slot frames are
// dropped and counted.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   s_axis_*              : receive stream (never back-pressured)
//   enb_o/web_o/addrb_o/dinb_o : registered port-B write, 1-cycle latency
//   frm_valid_o/slot/len  : descriptor of the oldest committed frame
//   frm_ack_i             : consumer releases that slot
//   drop_cnt_o            : saturating dropped-frame count
// ----------------------------------------------------------------------------
module eth_rx_frame_writer
    import eth_buf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              enb_o,
    output logic [1:0]        web_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [DATA_W-1:0] dinb_o,
    output logic              frm_valid_o,
    output logic              frm_slot_o,
    output logic [LEN_W-1:0]  frm_len_o,
    input  logic              frm_ack_i,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    wr_state_e          state_r;
    wr_state_e          state_nxt_s;
    logic [ADDR_W-1:0]  idx_r;
    logic [ADDR_W-1:0]  idx_nxt_s;
    logic               tready_r;
    logic               enb_r;
    logic [1:0]         web_r;
    logic [ADDR_W-1:0]  addrb_r;
    logic [DATA_W-1:0]  dinb_r;
    logic [CNT_W-1:0]   drop_cnt_r;

    logic               beat_s;
    logic               wr_s;
    logic               drop_inc_s;
    logic               commit_s;
    logic               good_s;
    logic [LEN_W-1:0]   len_s;
    logic               wslot_s;
    logic [1:0]         occ_s;
    logic               desc_valid_s;
    frm_desc_t          desc_s;

    assign beat_s = s_axis_tvalid & tready_r;

    // idx_r counts beats already written, so on tlast the frame holds
    // idx_r+1 beats and len = 8*idx_r + popcount(tkeep).
    assign len_s  = {idx_r, 3'b000} + {8'd0, keep_count(s_axis_tkeep)};
    assign good_s = ~s_axis_tuser & (len_s >= LEN_W'(MIN_LEN));

    // Writer FSM next-state, write strobe, commit and drop decisions.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wr_s        = 1'b0;
        drop_inc_s  = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!beat_s) begin
                    state_nxt_s = IDLE;
                end else if (occ_s[wslot_s]) begin
                    // Registered occ: an ack in this same cycle does not help.
                    drop_inc_s  = 1'b1;
                    state_nxt_s = s_axis_tlast ? IDLE : DROP;
                end else if (s_axis_tlast) begin
                    wr_s        = 1'b1;
                    commit_s    = good_s;
                    drop_inc_s  = ~good_s;
                    state_nxt_s = IDLE;
                end else begin
                    wr_s        = 1'b1;
                    idx_nxt_s   = ADDR_W'(1);
                    state_nxt_s = WRITE;
                end
            end
            WRITE: begin
                if (!beat_s) begin
                    state_nxt_s = WRITE;
                end else if (idx_r == ADDR_W'(SLOT_WORDS)) begin
                    // Slot full: oversize frame, counted once here.
                    drop_inc_s  = 1'b1;
                    idx_nxt_s   = {ADDR_W{1'b0}};
                    state_nxt_s = s_axis_tlast ? IDLE : DROP;
                end else if (s_axis_tlast) begin
                    wr_s        = 1'b1;
                    commit_s    = good_s;
                    drop_inc_s  = ~good_s;
                    idx_nxt_s   = {ADDR_W{1'b0}};
                    state_nxt_s = IDLE;
                end else begin
                    wr_s        = 1'b1;
                    idx_nxt_s   = idx_r + ADDR_W'(1);
                    state_nxt_s = WRITE;
                end
            end
            DROP: begin
                if (beat_s && s_axis_tlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM state and beat index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            idx_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Registered port-B driver, stream ready and saturating drop counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tready_r   <= 1'b0;
            enb_r      <= 1'b0;
            web_r      <= 2'b00;
            addrb_r    <= {ADDR_W{1'b0}};
            dinb_r     <= {DATA_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tready_r <= 1'b1;
            if (wr_s) begin
                enb_r   <= 1'b1;
                web_r   <= 2'b11;
                addrb_r <= {wslot_s, idx_r[ADDR_W-2:0]};
                dinb_r  <= s_axis_tdata;
            end else begin
                enb_r   <= 1'b0;
                web_r   <= 2'b00;
            end
            if (drop_inc_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end

    eth_slot_tracker u_slot_tracker (
        .clk        (clk_i),
        .rst        (rst_i),
        .commit     (commit_s),
        .commit_len (len_s),
        .ack        (frm_ack_i),
        .wslot      (wslot_s),
        .occ        (occ_s),
        .desc_valid (desc_valid_s),
        .desc       (desc_s)
    );

    assign s_axis_tready = tready_r;
    assign enb_o         = enb_r;
    assign web_o         = web_r;
    assign addrb_o       = addrb_r;
    assign dinb_o        = dinb_r;
    assign drop_cnt_o    = drop_cnt_r;
    assign frm_valid_o   = desc_valid_s;
    assign frm_slot_o    = desc_s.slot;
    assign frm_len_o     = desc_s.len;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// ----------------------------------------------------------------------------
// tb_eth_rx_frame_writer
// Directed self-checking bench for eth_rx_frame_writer. Inputs are driven on
// the falling edge, outputs sampled on the falling edge. Port-B writes are
// logged by a monitor and compared against hand-computed addresses/data.
// ----------------------------------------------------------------------------
module tb_eth_rx_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = 64'd0;
    logic [7:0]  tkeep = 8'd0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic        enb;
    logic [1:0]  web;
    logic [8:0]  addrb;
    logic [63:0] dinb;
    logic        frm_valid;
    logic        frm_slot;
    logic [11:0] frm_len;
    logic        frm_ack = 1'b0;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned first_cyc = 0;

    logic [8:0]  wa_q[$];
    logic [63:0] wd_q[$];
    int unsigned wc_q[$];

    always #5 clk = ~clk;

    eth_rx_frame_writer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .s_axis_tuser  (tuser),
        .enb_o         (enb),
        .web_o         (web),
        .addrb_o       (addrb),
        .dinb_o        (dinb),
        .frm_valid_o   (frm_valid),
        .frm_slot_o    (frm_slot),
        .frm_len_o     (frm_len),
        .frm_ack_i     (frm_ack),
        .drop_cnt_o    (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Port-B monitor: log every write, and web must track enb.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("web_vs_enb", {62'd0, web}, enb ? 64'd3 : 64'd0);
            if (enb) begin
                wa_q.push_back(addrb);
                wd_q.push_back(dinb);
                wc_q.push_back(cyc);
            end
        end
    end

    function automatic logic [63:0] beat_data(input logic [7:0] fid, input int b);
        return {fid, 24'd0, 32'(b)};
    endfunction

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic send_frame(input int nbeats, input logic [7:0] last_keep,
                              input logic user, input logic [7:0] fid,
                              input logic with_last, input logic ack_end);
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            if (b == 1) first_cyc = cyc;
            tvalid = 1'b1;
            tdata  = beat_data(fid, b);
            tlast  = with_last && (b == nbeats - 1);
            tkeep  = tlast ? last_keep : 8'hFF;
            tuser  = tlast ? user : 1'b0;
        end
        @(negedge clk);
        if (nbeats == 1) first_cyc = cyc;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tuser   = 1'b0;
        tkeep   = 8'h00;
        frm_ack = ack_end;
        if (ack_end) begin
            @(negedge clk);
            frm_ack = 1'b0;
        end
    endtask

    task automatic check_writes(input string tag, input int n, input int base, input logic [7:0] fid);
        chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(n));
        if (n > 0 && wa_q.size() == n) begin
            chk({tag, "_addr0"}, {55'd0, wa_q[0]}, 64'(base));
            chk({tag, "_addrN"}, {55'd0, wa_q[n-1]}, 64'(base + n - 1));
            chk({tag, "_dataN"}, wd_q[n-1], beat_data(fid, n - 1));
            chk({tag, "_lat"}, 64'(wc_q[0]), 64'(first_cyc));
            chk({tag, "_span"}, 64'(wc_q[n-1] - wc_q[0]), 64'(n - 1));
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        frm_ack = 1'b1;
        @(negedge clk);
        frm_ack = 1'b0;
    endtask

    task automatic chk_desc(input string tag, input logic v, input logic s, input int len);
        chk({tag, "_valid"}, {63'd0, frm_valid}, {63'd0, v});
        if (v) begin
            chk({tag, "_slot"}, {63'd0, frm_slot}, {63'd0, s});
            chk({tag, "_len"}, {52'd0, frm_len}, 64'(len));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, {63'd0, tready}, 64'd0);
        chk({tag, "_enb"}, {63'd0, enb}, 64'd0);
        chk({tag, "_addrb"}, {55'd0, addrb}, 64'd0);
        chk({tag, "_dinb"}, dinb, 64'd0);
        chk({tag, "_fvalid"}, {63'd0, frm_valid}, 64'd0);
        chk({tag, "_fslot"}, {63'd0, frm_slot}, 64'd0);
        chk({tag, "_flen"}, {52'd0, frm_len}, 64'd0);
        chk({tag, "_drop"}, {48'd0, drop_cnt}, 64'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);
        chk("tready_up", {63'd0, tready}, 64'd1);
        clear_log();

        // Single 64-byte frame
        send_frame(8, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0);
        chk_desc("f64_early", 1'b0, 1'b0, 0);
        @(negedge clk);
        chk_desc("f64", 1'b1, 1'b0, 64);
        check_writes("f64", 8, 0, 8'h01);
        do_ack();
        chk_desc("f64_ack", 1'b0, 1'b0, 0);

        // 61-byte then 1518-byte frame, then third frame with no free slot
        do_reset();
        send_frame(8, 8'h1F, 1'b0, 8'h02, 1'b1, 1'b0);
        @(negedge clk);
        chk_desc("f61", 1'b1, 1'b0, 61);
        check_writes("f61", 8, 0, 8'h02);
        clear_log();
        send_frame(190, 8'h3F, 1'b0, 8'h03, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("f1518", 190, 256, 8'h03);
        chk_desc("f1518_hold", 1'b1, 1'b0, 61);
        clear_log();
        send_frame(8, 8'hFF, 1'b0, 8'h04, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("full", 0, 0, 8'h04);
        chk("full_drop", {48'd0, drop_cnt}, 64'd1);
        do_ack();
        chk_desc("f1518", 1'b1, 1'b1, 1518);
        clear_log();
        send_frame(8, 8'hFF, 1'b0, 8'h05, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("reuse0", 8, 0, 8'h05);
        do_ack();
        chk_desc("f4th", 1'b1, 1'b0, 64);

        // Errored, runt and just-under-minimum frames
        do_reset();
        send_frame(8, 8'hFF, 1'b1, 8'h06, 1'b1, 1'b0);
        @(negedge clk);
        chk_desc("err", 1'b0, 1'b0, 0);
        chk("err_drop", {48'd0, drop_cnt}, 64'd1);
        clear_log();
        send_frame(8, 8'hFF, 1'b0, 8'h07, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("after_err", 8, 0, 8'h07);
        chk_desc("after_err", 1'b1, 1'b0, 64);
        clear_log();
        send_frame(5, 8'hFF, 1'b0, 8'h08, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("runt40", 5, 256, 8'h08);
        chk("runt40_drop", {48'd0, drop_cnt}, 64'd2);
        send_frame(8, 8'h07, 1'b0, 8'h09, 1'b1, 1'b0);
        @(negedge clk);
        chk("runt59_drop", {48'd0, drop_cnt}, 64'd3);
        chk_desc("runt_hold", 1'b1, 1'b0, 64);

        // Oversize frame of 300 beats
        do_reset();
        send_frame(300, 8'hFF, 1'b0, 8'h0A, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("over", 256, 0, 8'h0A);
        chk("over_drop", {48'd0, drop_cnt}, 64'd1);
        chk_desc("over", 1'b0, 1'b0, 0);
        clear_log();
        send_frame(8, 8'hFF, 1'b0, 8'h0B, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("after_over", 8, 0, 8'h0B);
        chk_desc("after_over", 1'b1, 1'b0, 64);

        // Ack in the same cycle as the next frame's commit (60 bytes = minimum)
        do_reset();
        send_frame(8, 8'hFF, 1'b0, 8'h0C, 1'b1, 1'b0);
        @(negedge clk);
        chk_desc("simA", 1'b1, 1'b0, 64);
        send_frame(8, 8'h0F, 1'b0, 8'h0D, 1'b1, 1'b1);
        chk_desc("simB", 1'b1, 1'b1, 60);
        do_ack();
        chk_desc("simB_ack", 1'b0, 1'b0, 0);

        // Reset in the middle of a frame
        do_reset();
        send_frame(8, 8'hFF, 1'b0, 8'h0E, 1'b1, 1'b0);
        send_frame(1, 8'hFF, 1'b0, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_pre_drop", {48'd0, drop_cnt}, 64'd1);
        chk_desc("mid_pre", 1'b1, 1'b0, 64);
        send_frame(4, 8'hFF, 1'b0, 8'h10, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        send_frame(8, 8'hFF, 1'b0, 8'h11, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("post_rst", 8, 0, 8'h11);
        chk_desc("post_rst", 1'b1, 1'b0, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
